// File: rtl/sr_flag_bank.sv
// sr_flag_bank
//   Bank of WIDTH clocked set/reset flags used as a peripheral interrupt-flag
//   register. Each flag is a synchronous SR cell. The set request can be
//   edge- or level-sensitive. When set and clear happen together, the
//   SET_DOMINANT parameter picks the winner. Software clears a flag by
//   writing a 1 to its bit (write-one-to-clear). A mask register gates the
//   flags into a registered irq, a lowest-index irq_vec and an acknowledge
//   handshake that clears the acknowledged flag.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset_n    synchronous reset, active low
//   set        per-channel hardware set request
//   clr        per-channel hardware clear request (level)
//   wr_en      flag-register write strobe
//   wr_data    write-one-to-clear data for the flag register
//   mask_wr_en mask-register write strobe
//   mask_data  new mask value (1 = channel enabled)
//   ack        interrupt acknowledge for the current irq_vec
//   flags      flag state
//   flags_n    inverted flag state
//   mask       mask register
//   irq        registered OR of flags & mask
//   irq_vec    registered index of the lowest set bit of flags & mask
module sr_flag_bank #(
  parameter int WIDTH        = 8,
  parameter bit SET_DOMINANT = 1'b0,
  parameter bit EDGE_SET     = 1'b1,
  localparam int VEC_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mask_wr_en,
  input  logic [WIDTH-1:0] mask_data,
  input  logic             ack,
  output logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] flags_n,
  output logic [WIDTH-1:0] mask,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec
);

  logic [WIDTH-1:0] flags_reg;
  logic [WIDTH-1:0] flags_next;
  logic [WIDTH-1:0] set_d_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] set_evt;
  logic [WIDTH-1:0] clr_evt;
  logic [WIDTH-1:0] ack_hit;
  logic             irq_reg;
  logic [VEC_W-1:0] vec_reg;
  logic [VEC_W-1:0] vec_next;
  logic             ack_blk_reg;
  logic             ack_acc;

  assign masked = flags_reg & mask_reg;

  // An ack is taken only against a live, registered irq. For one cycle after
  // an accepted ack, irq_vec still points at the channel that was just
  // cleared. ack_blk masks that cycle so a held ack cannot clear the same
  // channel again.
  assign ack_acc = ack & irq_reg & ~ack_blk_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign ack_hit[gi] = ack_acc & (vec_reg == VEC_W'(gi));
    assign set_evt[gi] = EDGE_SET ? (set[gi] & ~set_d_reg[gi]) : set[gi];
    assign clr_evt[gi] = clr[gi] | (wr_en & wr_data[gi]) | ack_hit[gi];
    assign flags_next[gi] = set_evt[gi] ? (clr_evt[gi] ? SET_DOMINANT : 1'b1)
                                        : (clr_evt[gi] ? 1'b0 : flags_reg[gi]);
  end

  // Lowest set index wins: scan from the top down so the last hit is the lowest.
  always_comb begin
    vec_next = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (masked[i]) vec_next = VEC_W'(i);
    end
  end

  // set_d is cleared in reset. A set held across the release of reset is
  // therefore seen as a rising edge on the first active cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_reg   <= '0;
      set_d_reg   <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
      vec_reg     <= '0;
      ack_blk_reg <= 1'b0;
    end else begin
      flags_reg   <= flags_next;
      set_d_reg   <= set;
      if (mask_wr_en) mask_reg <= mask_data;
      irq_reg     <= |masked;
      vec_reg     <= vec_next;
      ack_blk_reg <= ack_acc;
    end
  end

  assign flags   = flags_reg;
  assign flags_n = ~flags_reg;
  assign mask    = mask_reg;
  assign irq     = irq_reg;
  assign irq_vec = vec_reg;

endmodule
